// File: rtl/core_12bit.sv
`default_nettype none
// ============================================================================
// Module      : core_12bit
// Description : Multi-cycle 12-bit accumulator processor core with a private
//               instruction ROM (256 words) and a 1024 x 12 data RAM. It is
//               driven only by clock and reset. Once halted, a debug read port
//               dumps data memory through a flattened debug packet.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   I_WIDTH    : instruction / data word width (fixed at 12)
//   A_WIDTH    : PC / instruction-address width (ROM depth = 2**A_WIDTH)
//   ROM_IMAGE  : instruction ROM contents; word i sits at bits
//                [I_WIDTH*i +: I_WIDTH]. This image is what program.hex holds.
// Ports
//   clk           in   1  sole clock, rising edge
//   reset_i       in   1  synchronous, active-low reset
//   tb_mem_read_i in   1  debug data-memory read request
//   tb_addr_i     in  10  debug read address
//   debug_flat_o  out 24  {pc[7:0], substate[2:0], refused, dmem_out[11:0]}
// ============================================================================
module core_12bit #(
  parameter int I_WIDTH = 12,
  parameter int A_WIDTH = 8,
  parameter logic [(1 << A_WIDTH) * I_WIDTH - 1:0] ROM_IMAGE = '0
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        tb_mem_read_i,
  input  logic [9:0]  tb_addr_i,
  output logic [23:0] debug_flat_o
);

  localparam int c_ROM_DEPTH = 1 << A_WIDTH;
  localparam int c_RAM_DEPTH = 1024;

  // Opcodes (ir[11:8])
  localparam logic [3:0] c_OP_HALT = 4'h0;
  localparam logic [3:0] c_OP_LDI  = 4'h1;
  localparam logic [3:0] c_OP_LD   = 4'h2;
  localparam logic [3:0] c_OP_ST   = 4'h3;
  localparam logic [3:0] c_OP_ADD  = 4'h4;
  localparam logic [3:0] c_OP_SUB  = 4'h5;
  localparam logic [3:0] c_OP_AND  = 4'h6;
  localparam logic [3:0] c_OP_OR   = 4'h7;
  localparam logic [3:0] c_OP_ADDI = 4'h8;
  localparam logic [3:0] c_OP_SHL  = 4'h9;
  localparam logic [3:0] c_OP_SHR  = 4'hA;
  localparam logic [3:0] c_OP_BZ   = 4'hB;
  localparam logic [3:0] c_OP_BNZ  = 4'hC;
  localparam logic [3:0] c_OP_JMP  = 4'hD;
  localparam logic [3:0] c_OP_GRP  = 4'hE;
  localparam logic [3:0] c_OP_NOP  = 4'hF;

  // Index-register group sub-operations (k[1:0] when op = E)
  localparam logic [1:0] c_GRP_LDX = 2'd0;
  localparam logic [1:0] c_GRP_STX = 2'd1;
  localparam logic [1:0] c_GRP_TAX = 2'd2;
  localparam logic [1:0] c_GRP_INX = 2'd3;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_HALT    = 3'd7
  } state_t;

  // --------------------------------------------------------------------------
  // Architectural and pipeline state
  // --------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_next;
  logic [A_WIDTH-1:0] r_pc;
  logic [I_WIDTH-1:0] r_acc;
  logic [9:0]         r_x;
  logic [I_WIDTH-1:0] r_ir;
  logic [I_WIDTH-1:0] r_fetch;     // ROM output captured in sFetch
  logic [I_WIDTH-1:0] r_mem_q;     // RAM read data for the executing op
  logic [I_WIDTH-1:0] r_dmem_out;  // debug read data
  logic               r_refused;

  logic [I_WIDTH-1:0] r_ram [c_RAM_DEPTH];

  // --------------------------------------------------------------------------
  // Instruction ROM: unpack the flat image into a word array
  // --------------------------------------------------------------------------
  logic [I_WIDTH-1:0] w_rom [c_ROM_DEPTH];
  logic [I_WIDTH-1:0] w_rom_word;

  for (genvar gi = 0; gi < c_ROM_DEPTH; gi++) begin : g_rom
    assign w_rom[gi] = ROM_IMAGE[gi*I_WIDTH +: I_WIDTH];
  end

  assign w_rom_word = w_rom[r_pc];

  // --------------------------------------------------------------------------
  // Instruction field decode
  // --------------------------------------------------------------------------
  logic [3:0]         w_op;
  logic [7:0]         w_k;
  logic [I_WIDTH-1:0] w_sext_k;
  logic [3:0]         w_fetch_op;
  logic [1:0]         w_fetch_sub;
  logic               w_needs_mem;

  assign w_op        = r_ir[11:8];
  assign w_k         = r_ir[7:0];
  assign w_sext_k    = {{(I_WIDTH-8){w_k[7]}}, w_k};

  // The next-state choice out of sDecode is made on the word being latched,
  // since r_ir only holds it after that same edge.
  assign w_fetch_op  = r_fetch[11:8];
  assign w_fetch_sub = r_fetch[1:0];

  always_comb begin
    w_needs_mem = 1'b0;
    case (w_fetch_op)
      c_OP_LD, c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR: w_needs_mem = 1'b1;
      c_OP_GRP: w_needs_mem = (w_fetch_sub == c_GRP_LDX);
      default:  w_needs_mem = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_INIT:    w_state_next = S_FETCH;
      S_FETCH:   w_state_next = S_DECODE;
      S_DECODE: begin
        if (w_fetch_op == c_OP_HALT) begin
          w_state_next = S_HALT;
        end else if (w_needs_mem) begin
          w_state_next = S_MEM;
        end else begin
          w_state_next = S_EXECUTE;
        end
      end
      S_MEM:     w_state_next = S_EXECUTE;
      S_EXECUTE: w_state_next = S_FETCH;
      S_HALT:    w_state_next = S_HALT;
      default:   w_state_next = S_INIT;
    endcase
  end

  // --------------------------------------------------------------------------
  // Execute datapath: results applied on the sExecute edge
  // --------------------------------------------------------------------------
  logic [I_WIDTH-1:0] w_acc_next;
  logic [9:0]         w_x_next;
  logic               w_pc_load;
  logic               w_mem_we;
  logic [9:0]         w_mem_waddr;

  always_comb begin
    w_acc_next  = r_acc;
    w_x_next    = r_x;
    w_pc_load   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_waddr = {2'b00, w_k};
    case (w_op)
      c_OP_LDI:  w_acc_next = w_sext_k;
      c_OP_LD:   w_acc_next = r_mem_q;
      c_OP_ST:   w_mem_we   = 1'b1;
      c_OP_ADD:  w_acc_next = r_acc + r_mem_q;
      c_OP_SUB:  w_acc_next = r_acc - r_mem_q;
      c_OP_AND:  w_acc_next = r_acc & r_mem_q;
      c_OP_OR:   w_acc_next = r_acc | r_mem_q;
      c_OP_ADDI: w_acc_next = r_acc + w_sext_k;
      // Shift amounts of 12..15 move every bit out, leaving zero.
      c_OP_SHL:  w_acc_next = r_acc << w_k[3:0];
      c_OP_SHR:  w_acc_next = r_acc >> w_k[3:0];
      c_OP_BZ:   w_pc_load  = (r_acc == '0);
      c_OP_BNZ:  w_pc_load  = (r_acc != '0);
      c_OP_JMP:  w_pc_load  = 1'b1;
      c_OP_GRP: begin
        case (w_k[1:0])
          c_GRP_LDX: w_acc_next = r_mem_q;
          c_GRP_STX: begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_x;
          end
          c_GRP_TAX: w_x_next = r_acc[9:0];
          c_GRP_INX: w_x_next = r_x + 10'd1;  // wraps 1023 -> 0
          default:   w_x_next = r_x;
        endcase
      end
      default: w_acc_next = r_acc;  // HALT never executes; NOP does nothing
    endcase
  end

  // --------------------------------------------------------------------------
  // RAM read address: the debug port only owns it while halted, when the
  // core itself never reads.
  // --------------------------------------------------------------------------
  logic [9:0] w_rd_addr;
  logic       w_dbg_accept;

  assign w_dbg_accept = (r_state == S_HALT) && tb_mem_read_i;

  always_comb begin
    if (r_state == S_HALT) begin
      w_rd_addr = tb_addr_i;
    end else if (w_op == c_OP_GRP) begin
      w_rd_addr = r_x;
    end else begin
      w_rd_addr = {2'b00, w_k};
    end
  end

  // --------------------------------------------------------------------------
  // Core state registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_i) begin
      r_state <= S_INIT;
      r_pc    <= '0;
      r_acc   <= '0;
      r_x     <= '0;
      r_ir    <= '0;
      r_fetch <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_FETCH: r_fetch <= w_rom_word;
        S_DECODE: begin
          r_ir <= r_fetch;
          r_pc <= r_pc + 1'b1;
        end
        S_EXECUTE: begin
          r_acc <= w_acc_next;
          r_x   <= w_x_next;
          if (w_pc_load) begin
            r_pc <= w_k[A_WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Data RAM: contents survive reset. A store whose sExecute edge meets an
  // asserted reset is suppressed so the aborted instruction leaves no trace.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset_i && (r_state == S_EXECUTE) && w_mem_we) begin
      r_ram[w_mem_waddr] <= r_acc;
    end
    if (r_state == S_MEM) begin
      r_mem_q <= r_ram[w_rd_addr];
    end
  end

  // --------------------------------------------------------------------------
  // Debug read port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_i) begin
      r_dmem_out <= '0;
      r_refused  <= 1'b0;
    end else begin
      r_refused <= tb_mem_read_i && (r_state != S_HALT);
      if (w_dbg_accept) begin
        r_dmem_out <= r_ram[w_rd_addr];
      end
    end
  end

  assign debug_flat_o = {r_pc[7:0], r_state, r_refused, r_dmem_out};

endmodule
`default_nettype wire

// File: tb/tb_core_12bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_12bit
// Description : Self-checking bench for core_12bit. Four core instances each
//               carry one test program in ROM; results are dumped through the
//               debug read port after HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_12bit;

  // LDI 5; ADDI -2; ST 0x10; HALT
  localparam logic [3071:0] PROG_A =
    3072'({12'h000, 12'h310, 12'h8FE, 12'h105});
  // LDI 3; L: ADDI -1; BNZ L; ST 0x20; HALT
  localparam logic [3071:0] PROG_LOOP =
    3072'({12'h000, 12'h320, 12'hC01, 12'h8FF, 12'h103});
  // LDI -1 (acc[9:0]=0x3FF); TAX; LDI 7; STX; INX; STX; HALT
  localparam logic [3071:0] PROG_WRAP =
    3072'({12'h000, 12'hE01, 12'hE03, 12'hE01, 12'h107, 12'hE02, 12'h1FF});
  // Every opcode; results stored to 0x40..0x4F and M[2]. Words 46..0.
  localparam logic [3071:0] PROG_ALU = 3072'({
    12'h000, 12'h34E, 12'h801, 12'hE00, 12'h100, 12'hE01, 12'h177, 12'hE03,
    12'hE02, 12'h34D, 12'h801, 12'hF00, 12'hC00, 12'hA0F, 12'h34F, 12'hA04,
    12'h34C, 12'h880, 12'h34A, 12'h166, 12'hD1D, 12'h34A, 12'hB1B, 12'h155,
    12'h348, 12'h111, 12'hB17, 12'h348, 12'h90C, 12'h347, 12'hA05, 12'h346,
    12'h903, 12'h345, 12'h740, 12'h10F, 12'h344, 12'h640, 12'h343, 12'h540,
    12'h342, 12'h441, 12'h240, 12'h341, 12'h1F0, 12'h340, 12'h12A});

  localparam int BUDGET = 2000;

  logic        clk = 1'b0;
  logic        rst_n [4];
  logic        rd    [4];
  logic [9:0]  addr  [4];
  logic [23:0] dbg   [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_12bit #(.ROM_IMAGE(PROG_A)) u_a (
    .clk(clk), .reset_i(rst_n[0]), .tb_mem_read_i(rd[0]),
    .tb_addr_i(addr[0]), .debug_flat_o(dbg[0]));
  core_12bit #(.ROM_IMAGE(PROG_LOOP)) u_loop (
    .clk(clk), .reset_i(rst_n[1]), .tb_mem_read_i(rd[1]),
    .tb_addr_i(addr[1]), .debug_flat_o(dbg[1]));
  core_12bit #(.ROM_IMAGE(PROG_WRAP)) u_wrap (
    .clk(clk), .reset_i(rst_n[2]), .tb_mem_read_i(rd[2]),
    .tb_addr_i(addr[2]), .debug_flat_o(dbg[2]));
  core_12bit #(.ROM_IMAGE(PROG_ALU)) u_alu (
    .clk(clk), .reset_i(rst_n[3]), .tb_mem_read_i(rd[3]),
    .tb_addr_i(addr[3]), .debug_flat_o(dbg[3]));

  typedef struct {
    logic [9:0]  addr;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [15];

  function automatic logic [7:0]  f_pc(input logic [23:0] d); return d[23:16]; endfunction
  function automatic logic [2:0]  f_st(input logic [23:0] d); return d[15:13]; endfunction
  function automatic logic        f_rf(input logic [23:0] d); return d[12];    endfunction
  function automatic logic [11:0] f_dm(input logic [23:0] d); return d[11:0];  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Release reset; the edge that follows moves the core into sFetch.
  task automatic start(input int idx);
    rst_n[idx] = 1'b1;
    step();
  endtask

  // Step until sHalt; cycles counts edges after the first sFetch edge and
  // fetches counts samples spent in sFetch (one per instruction).
  task automatic wait_halt(input int idx, output int cycles, output int fetches);
    cycles  = 0;
    fetches = (f_st(dbg[idx]) == 3'd1) ? 1 : 0;
    while (f_st(dbg[idx]) != 3'd7 && cycles < BUDGET) begin
      step();
      cycles++;
      if (f_st(dbg[idx]) == 3'd1) fetches++;
    end
    if (f_st(dbg[idx]) != 3'd7) begin
      checks++;
      errors++;
      $display("FAIL halt_timeout[%0d]: substate 0x%0h after %0d cycles, expected 0x7",
               idx, f_st(dbg[idx]), cycles);
    end
  endtask

  task automatic dbg_read(input int idx, input logic [9:0] a, input logic [11:0] exp,
                          input string name);
    rd[idx]   = 1'b1;
    addr[idx] = a;
    step();
    check(name, f_dm(dbg[idx]), exp);
    check({name, "_refused"}, f_rf(dbg[idx]), 1'b0);
    rd[idx] = 1'b0;
  endtask

  initial begin
    int cyc;
    int fet;

    vecs[0]  = '{10'h040, 12'h02A};  // LDI sign-positive
    vecs[1]  = '{10'h041, 12'hFF0};  // LDI sign-extended
    vecs[2]  = '{10'h042, 12'h01A};  // ADD wraps mod 4096
    vecs[3]  = '{10'h043, 12'hFF0};  // SUB borrow
    vecs[4]  = '{10'h044, 12'h020};  // AND
    vecs[5]  = '{10'h045, 12'h02F};  // OR
    vecs[6]  = '{10'h046, 12'h178};  // SHL 3
    vecs[7]  = '{10'h047, 12'h00B};  // SHR 5
    vecs[8]  = '{10'h048, 12'h000};  // SHL 12 -> 0, BZ taken skips ST
    vecs[9]  = '{10'h04A, 12'h055};  // BZ not taken, JMP skips LDI/ST
    vecs[10] = '{10'h04C, 12'hFD5};  // ADDI -128
    vecs[11] = '{10'h04F, 12'h0FD};  // SHR is logical
    vecs[12] = '{10'h04D, 12'h001};  // SHR 15 -> 0, BNZ not taken
    vecs[13] = '{10'h002, 12'h077};  // TAX/INX/STX
    vecs[14] = '{10'h04E, 12'h078};  // LDX

    for (int i = 0; i < 4; i++) begin
      rst_n[i] = 1'b0;
      rd[i]    = 1'b0;
      addr[i]  = '0;
    end

    // ---------------- reset state and straight-line program ----------------
    step();
    step();
    check("rst_substate", f_st(dbg[0]), 3'd0);
    check("rst_pc",       f_pc(dbg[0]), 8'd0);
    check("rst_refused",  f_rf(dbg[0]), 1'b0);
    check("rst_dmem",     f_dm(dbg[0]), 12'd0);
    start(0);
    check("first_fetch_substate", f_st(dbg[0]), 3'd1);
    check("first_fetch_pc",       f_pc(dbg[0]), 8'd0);
    wait_halt(0, cyc, fet);
    check("a_halt_cycle", cyc, 11);
    check("a_halt_pc",    f_pc(dbg[0]), 8'd4);
    dbg_read(0, 10'h010, 12'h003, "a_M10");

    // ---------------- debug request refused while running ----------------
    rst_n[0] = 1'b0;
    rd[0]    = 1'b1;
    addr[0]  = 10'h010;
    step();
    check("rerun_rst_dmem",    f_dm(dbg[0]), 12'd0);
    check("rerun_rst_refused", f_rf(dbg[0]), 1'b0);
    start(0);
    check("refused_running",   f_rf(dbg[0]), 1'b1);
    check("dmem_hold_running", f_dm(dbg[0]), 12'd0);
    wait_halt(0, cyc, fet);
    check("rerun_halt_cycle", cyc, 11);
    step();
    check("halt_read_refused", f_rf(dbg[0]), 1'b0);
    check("halt_read_dmem",    f_dm(dbg[0]), 12'h003);
    rd[0] = 1'b0;

    // ---------------- loop ----------------
    start(1);
    wait_halt(1, cyc, fet);
    check("loop_fetches", fet, 9);
    dbg_read(1, 10'h020, 12'h000, "loop_M20");

    // ---------------- index register wrap ----------------
    start(2);
    wait_halt(2, cyc, fet);
    dbg_read(2, 10'h3FF, 12'h007, "wrap_M3FF");
    dbg_read(2, 10'h000, 12'h007, "wrap_M000");

    // ---------------- reset during sMem of LD, then full rerun ----------------
    start(3);
    cyc = 0;
    while (f_st(dbg[3]) != 3'd4 && cyc < BUDGET) begin
      step();
      cyc++;
    end
    check("ld_mem_substate", f_st(dbg[3]), 3'd4);
    check("ld_mem_pc",       f_pc(dbg[3]), 8'd5);
    rst_n[3] = 1'b0;
    step();
    check("midrst_substate", f_st(dbg[3]), 3'd0);
    check("midrst_pc",       f_pc(dbg[3]), 8'd0);
    check("midrst_acc",      u_alu.r_acc, 12'd0);
    start(3);
    wait_halt(3, cyc, fet);
    for (int i = 0; i < 15; i++) begin
      dbg_read(3, vecs[i].addr, vecs[i].exp, $sformatf("alu_M%03h", vecs[i].addr));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
